// File: rtl/sig_dump_ctrl_pkg.sv
// Shared constants for the signature dump engine:
// FSM state codes, fail codes, default map addresses, timer width.
package sig_dump_ctrl_pkg;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_POLL_WAIT = 4'd1;
   localparam logic [3:0] ST_POLL_RD   = 4'd2;
   localparam logic [3:0] ST_RD_BEGIN  = 4'd3;
   localparam logic [3:0] ST_RD_END    = 4'd4;
   localparam logic [3:0] ST_CHECK     = 4'd5;
   localparam logic [3:0] ST_RD_WORD   = 4'd6;
   localparam logic [3:0] ST_EMIT      = 4'd7;
   localparam logic [3:0] ST_DONE      = 4'd8;
   localparam logic [3:0] ST_FAIL      = 4'd9;

   localparam logic [1:0] SIG_FAIL_NONE    = 2'b00;
   localparam logic [1:0] SIG_FAIL_ORDER   = 2'b01;
   localparam logic [1:0] SIG_FAIL_RANGE   = 2'b10;
   localparam logic [1:0] SIG_FAIL_TIMEOUT = 2'b11;

   localparam logic [31:0] SIG_DEF_FLAG_ADDR  = 32'h10;
   localparam logic [31:0] SIG_DEF_BEGIN_ADDR = 32'h08;
   localparam logic [31:0] SIG_DEF_END_ADDR   = 32'h0C;

   localparam int unsigned SIG_TMR_W = 32;

endpackage

// File: rtl/sig_dump_ctrl_timer.sv
// Timeout counter: clr zeroes, en counts, expired fires on the
// cycle that would reach TIMEOUT_CYCLES (never when TIMEOUT_CYCLES=0).
// Ports: clk, rst, clr, en -> expired.
module sig_dump_ctrl_timer
   import sig_dump_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 25000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [SIG_TMR_W-1:0] LAST =
      SIG_TMR_W'(TIMEOUT_CYCLES - 1);
   localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

   logic [SIG_TMR_W-1:0] cnt_q;
   logic [SIG_TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = ENABLED && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/sig_dump_ctrl.sv
// Compliance-signature dump engine: polls an end-of-test flag, fetches
// the [begin,end) pointers, reads each word and streams it out.
// Ports: clk/rst, start/abort control; mem_req/mem_addr/mem_rvalid/
// mem_rdata read port; sig_valid/sig_ready/sig_data/sig_last stream;
// busy/done/fail/fail_code/word_count status.
module sig_dump_ctrl
   import sig_dump_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] FLAG_ADDR  =
      ADDR_WIDTH'(SIG_DEF_FLAG_ADDR),
   parameter logic [ADDR_WIDTH-1:0] BEGIN_ADDR =
      ADDR_WIDTH'(SIG_DEF_BEGIN_ADDR),
   parameter logic [ADDR_WIDTH-1:0] END_ADDR   =
      ADDR_WIDTH'(SIG_DEF_END_ADDR),
   parameter logic [DATA_WIDTH-1:0] FLAG_VALUE = DATA_WIDTH'(1),
   parameter int unsigned POLL_INTERVAL  = 16,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 25000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  sig_valid,
   input  logic                  sig_ready,
   output logic [DATA_WIDTH-1:0] sig_data,
   output logic                  sig_last,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [1:0]            fail_code,
   output logic [15:0]           word_count
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned LSB   = $clog2(BYTES);
   localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BYTES);
   localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] MAXW  = ADDR_WIDTH'(MAX_WORDS);
   localparam logic [15:0] PI_LAST = 16'(POLL_INTERVAL - 1);

   logic [3:0]            state_q, state_d;
   logic                  pend_q, pend_d;
   logic [15:0]           wait_q, wait_d;
   logic [ADDR_WIDTH-1:0] beg_q, beg_d;
   logic [ADDR_WIDTH-1:0] end_q, end_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  done_q, done_d;
   logic                  fail_q, fail_d;
   logic [1:0]            code_q, code_d;
   logic [15:0]           cnt_q, cnt_d;

   logic                  tmr_clr;
   logic                  tmr_exp;
   logic                  is_busy;
   logic                  rd_ok;
   logic                  is_last;
   logic [ADDR_WIDTH-1:0] span;
   logic                  misalign;
   logic                  too_big;
   logic [ADDR_WIDTH-1:0] rd_ptr;

   assign is_busy = (state_q != ST_IDLE) &&
                    (state_q != ST_DONE) &&
                    (state_q != ST_FAIL);

   // Only a response to our own outstanding read is consumed.
   assign rd_ok    = pend_q && mem_rvalid;
   assign rd_ptr   = ADDR_WIDTH'(mem_rdata);
   assign is_last  = (addr_q + STEP) == end_q;
   assign span     = end_q - beg_q;
   assign misalign = ((beg_q & AMASK) != '0) ||
                     ((end_q & AMASK) != '0);
   assign too_big  = (span >> LSB) > MAXW;

   sig_dump_ctrl_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmr_clr),
      .en     (is_busy),
      .expired(tmr_exp)
   );

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      wait_d   = wait_q;
      beg_d    = beg_q;
      end_d    = end_q;
      addr_d   = addr_q;
      data_d   = data_q;
      done_d   = done_q;
      fail_d   = fail_q;
      code_d   = code_q;
      cnt_d    = cnt_q;
      tmr_clr  = 1'b0;
      mem_req  = 1'b0;
      mem_addr = '0;

      if (abort) begin
         state_d = ST_IDLE;
         pend_d  = 1'b0;
         done_d  = 1'b0;
         fail_d  = 1'b0;
         code_d  = SIG_FAIL_NONE;
      end else if (start && !is_busy) begin
         state_d = ST_POLL_RD;
         pend_d  = 1'b0;
         done_d  = 1'b0;
         fail_d  = 1'b0;
         code_d  = SIG_FAIL_NONE;
         cnt_d   = '0;
         tmr_clr = 1'b1;
      end else if (tmr_exp) begin
         // Wins over any rvalid or handshake in the same cycle.
         state_d = ST_FAIL;
         pend_d  = 1'b0;
         fail_d  = 1'b1;
         code_d  = SIG_FAIL_TIMEOUT;
      end else begin
         case (state_q)
            ST_POLL_WAIT: begin
               wait_d = wait_q + 1'b1;
               if (wait_q == PI_LAST)
                  state_d = ST_POLL_RD;
            end
            ST_POLL_RD: begin
               if (!pend_q) begin
                  mem_req  = 1'b1;
                  mem_addr = FLAG_ADDR;
                  pend_d   = 1'b1;
               end else if (rd_ok) begin
                  pend_d = 1'b0;
                  wait_d = '0;
                  if (mem_rdata == FLAG_VALUE)
                     state_d = ST_RD_BEGIN;
                  else
                     state_d = ST_POLL_WAIT;
               end
            end
            ST_RD_BEGIN: begin
               if (!pend_q) begin
                  mem_req  = 1'b1;
                  mem_addr = BEGIN_ADDR;
                  pend_d   = 1'b1;
               end else if (rd_ok) begin
                  pend_d  = 1'b0;
                  beg_d   = rd_ptr;
                  state_d = ST_RD_END;
               end
            end
            ST_RD_END: begin
               if (!pend_q) begin
                  mem_req  = 1'b1;
                  mem_addr = END_ADDR;
                  pend_d   = 1'b1;
               end else if (rd_ok) begin
                  pend_d  = 1'b0;
                  end_d   = rd_ptr;
                  state_d = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (end_q < beg_q) begin
                  state_d = ST_FAIL;
                  fail_d  = 1'b1;
                  code_d  = SIG_FAIL_ORDER;
               end else if (misalign || too_big) begin
                  state_d = ST_FAIL;
                  fail_d  = 1'b1;
                  code_d  = SIG_FAIL_RANGE;
               end else if (end_q == beg_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  addr_d  = beg_q;
                  state_d = ST_RD_WORD;
               end
            end
            ST_RD_WORD: begin
               if (!pend_q) begin
                  mem_req  = 1'b1;
                  mem_addr = addr_q;
                  pend_d   = 1'b1;
               end else if (rd_ok) begin
                  pend_d  = 1'b0;
                  data_d  = mem_rdata;
                  state_d = ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (sig_ready) begin
                  cnt_d  = cnt_q + 1'b1;
                  addr_d = addr_q + STEP;
                  if (is_last) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RD_WORD;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
         wait_q  <= '0;
         beg_q   <= '0;
         end_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         code_q  <= SIG_FAIL_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         wait_q  <= wait_d;
         beg_q   <= beg_d;
         end_q   <= end_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sig_valid  = (state_q == ST_EMIT);
   assign sig_data   = data_q;
   assign sig_last   = sig_valid && is_last;
   assign busy       = is_busy;
   assign done       = done_q;
   assign fail       = fail_q;
   assign fail_code  = code_q;
   assign word_count = cnt_q;

endmodule
